// File: rtl/npc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : npc_pkg
// Brief    : Shared next-PC select encodings and default PC constants.
// Revision : 1.0
// ============================================================================
package npc_pkg;

    typedef enum logic [2:0] {
        NPC_N    = 3'd0,
        NPC_B    = 3'd1,
        NPC_J    = 3'd2,
        NPC_JR   = 3'd3,
        NPC_JAL  = 3'd4,
        NPC_JALR = 3'd5,
        NPC_JRRA = 3'd6
    } npc_op_e;

    localparam logic [31:0] c_reset_pc   = 32'h0000_3000;
    localparam logic [31:0] c_exc_vector = 32'h0000_4180;

    // Link instructions push their return address onto the RAS.
    function automatic logic is_link(input logic [2:0] op);
        return (op == NPC_JAL) || (op == NPC_JALR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
// Module   : ras_stack
// Brief    : Circular return-address stack with saturating occupancy count.
// Revision : 1.0
// ============================================================================
module ras_stack #(
    parameter int RAS_DEPTH = 8,
    parameter int PTR_W     = $clog2(RAS_DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] din,
    output logic [31:0] top,
    output logic        empty,
    output logic        full
);

    localparam logic [PTR_W:0] c_depth = (PTR_W + 1)'(RAS_DEPTH);

    logic [31:0]      r_mem [RAS_DEPTH];
    logic [PTR_W-1:0] r_ptr;      // next free slot; top entry sits just below
    logic [PTR_W:0]   r_count;
    logic [PTR_W-1:0] w_top_idx;

    assign w_top_idx = r_ptr - 1'b1;

    // When full, the write slot coincides with the oldest entry, so a push
    // naturally overwrites it while the count saturates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr   <= '0;
            r_count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (push) begin
            r_mem[r_ptr] <= din;
            r_ptr        <= r_ptr + 1'b1;
            if (r_count != c_depth) begin
                r_count <= r_count + 1'b1;
            end
        end else if (pop && (r_count != '0)) begin
            r_ptr   <= w_top_idx;
            r_count <= r_count - 1'b1;
        end
    end

    assign top   = r_mem[w_top_idx];
    assign empty = (r_count == '0);
    assign full  = (r_count == c_depth);

endmodule
`default_nettype wire

// File: rtl/npc_ras.sv
`default_nettype none
// ============================================================================
// Module   : npc_ras
// Brief    : Fetch PC register and next-PC selection with RAS-predicted jr $ra.
// Revision : 1.0
// ============================================================================
module npc_ras
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = c_reset_pc,
    parameter logic [31:0] EXC_VECTOR = c_exc_vector,
    parameter int          RAS_DEPTH  = 8,
    parameter int          PTR_W      = $clog2(RAS_DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        fix,
    input  logic [31:0] fix_pc,
    input  logic        stall,
    input  logic [2:0]  op_npc,
    input  logic        b_flag,
    input  logic [31:0] d_pc,
    input  logic [31:0] br_off,
    input  logic [25:0] index,
    input  logic [31:0] rs,
    output logic [31:0] f_pc,
    output logic [31:0] npc,
    output logic        ras_used,
    output logic        ras_empty,
    output logic        ras_full
);

    logic [31:0] r_f_pc;
    logic [31:0] w_seq_pc;
    logic [31:0] w_br_target;
    logic [31:0] w_jump_target;
    logic [31:0] w_ras_top;
    logic        w_override;
    logic        w_push;
    logic        w_pop;

    assign w_seq_pc      = r_f_pc + 32'd4;
    assign w_br_target   = d_pc + 32'd4 + (br_off << 2);
    assign w_jump_target = {d_pc[31:28], index, 2'b00};

    // Any redirect or stall means the D-stage instruction is not advancing,
    // so it must not touch the RAS.
    assign w_override = req | eret | fix | stall;
    assign w_push     = !w_override && is_link(op_npc);
    assign w_pop      = !w_override && (op_npc == NPC_JRRA) && !ras_empty;
    assign ras_used   = w_pop;

    always_comb begin
        npc = w_seq_pc;
        if (req) begin
            npc = EXC_VECTOR;
        end else if (eret) begin
            npc = epc;
        end else if (fix) begin
            npc = fix_pc;
        end else if (stall) begin
            npc = r_f_pc;
        end else begin
            case (op_npc)
                NPC_B:              npc = b_flag ? w_br_target : w_seq_pc;
                NPC_J, NPC_JAL:     npc = w_jump_target;
                NPC_JR, NPC_JALR:   npc = rs;
                NPC_JRRA:           npc = ras_empty ? rs : w_ras_top;
                default:            npc = w_seq_pc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_f_pc <= RESET_PC;
        end else begin
            r_f_pc <= npc;
        end
    end

    assign f_pc = r_f_pc;

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .PTR_W     (PTR_W)
    ) u_ras_stack (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (d_pc + 32'd8),
        .top   (w_ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

endmodule
`default_nettype wire

// File: doc/npc_ras.md
# npc_ras

Parametrised fetch-PC unit: owns the F-stage PC register and computes the next PC from exception, eret, misprediction-repair, stall and D-stage control-transfer requests. A return-address stack (RAS) predicts `jr $ra` targets so D does not stall on a late `$ra`; E-stage resolution repairs mispredictions. Sits between the D-stage decoder/comparator and the instruction-memory address port.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, value of `f_pc` after reset
- `EXC_VECTOR`, 32'h0000_4180, exception handler entry
- `RAS_DEPTH`, 8, RAS entries, power of two, ≥2
- `PTR_W`, $clog2(RAS_DEPTH), RAS pointer width

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `req` in 1: exception/interrupt taken this cycle
- `eret` in 1: eret in D
- `epc` in 32: return address for eret
- `fix` in 1: E stage reports a mispredicted `jr $ra`
- `fix_pc` in 32: correct target for `fix`
- `stall` in 1: hold F/D
- `op_npc` in 3: N=0, B=1, J=2, JR=3, JAL=4, JALR=5, JRRA=6; 7 treated as N
- `b_flag` in 1: branch condition true
- `d_pc` in 32: PC of the instruction in D
- `br_off` in 32: sign-extended 16-bit branch offset
- `index` in 26: j/jal index
- `rs` in 32: forwarded rs value
- `f_pc` out 32: registered fetch PC
- `npc` out 32: combinational next PC
- `ras_used` out 1: JRRA target came from the RAS
- `ras_empty` out 1, `ras_full` out 1: RAS occupancy flags

## Operation
- `npc` priority: `req` → EXC_VECTOR; else `eret` → `epc`; else `fix` → `fix_pc`; else `stall` → `f_pc`; else by `op_npc`:
  - N: `f_pc`+4
  - B: `b_flag` ? `d_pc`+4+(`br_off`<<2) : `f_pc`+4
  - J, JAL: {`d_pc`[31:28], `index`, 2'b00}
  - JR, JALR: `rs`
  - JRRA: RAS non-empty ? top entry : `rs`
- All adds are 32-bit modulo 2^32, no overflow detection.
- RAS is a circular buffer with a top pointer and a saturating count 0..RAS_DEPTH.
- Push on JAL/JALR; pushed value is `d_pc`+8 (delay slot).
- Pop on JRRA when count>0. JRRA with an empty RAS pops nothing.
- Push when full overwrites the oldest entry; the pointer wraps and count stays RAS_DEPTH.
- Push and pop are suppressed when any of `req`, `eret`, `fix` or `stall` is high.
- The RAS is not checkpointed. A `fix` leaves the RAS as is.
- `ras_used` = (`op_npc`==JRRA) & count>0 & no higher-priority condition active.
- `ras_empty` = count==0; `ras_full` = count==RAS_DEPTH.

## Timing
- While `reset`=0: `f_pc`=RESET_PC, count=0, pointer=0, all entries 0. `ras_empty`=1, `ras_full`=0.
- `npc` is combinational from the current inputs.
- `f_pc` <= `npc` on every rising edge. On `stall`, `npc`==`f_pc`, so the PC holds.
- RAS updates on the same edge. An entry pushed at edge k is visible as top to a JRRA in cycle k+1.
- Reset asserted mid-operation returns the PC and RAS to reset values immediately, without waiting for a clock edge.
- Simultaneous `req` and `eret`/`fix`: `req` wins and the RAS does not change.

## Structure
- Shared package `npc_pkg`:
  - `op_npc` encodings (NPC_N … NPC_JRRA)
  - default RESET_PC and EXC_VECTOR
- Sub-module `ras_stack`:
  - parameters RAS_DEPTH and PTR_W
  - ports: push, pop, din, top, empty, full
- `npc_ras` contains the priority mux, the PC register and one `ras_stack` instance.

## Test plan
- Reset release, `op_npc`=N for 3 cycles → `f_pc` = 0x3000, 0x3004, 0x3008, 0x300C.
- JAL with `d_pc`=0x3010, then JRRA the next cycle with `rs`=0xDEAD → the JRRA `npc`=0x3018, `ras_used`=1, `ras_empty`=1 afterwards.
- RAS_DEPTH+1 pushes with `d_pc`=0x3000+16·i, then RAS_DEPTH+1 JRRA:
  - `ras_full` stays 1 after the last push
  - the pops return the newest RAS_DEPTH values
  - the final JRRA falls back to `rs` with `ras_used`=0
- B with `b_flag`=1, `d_pc`=0x3020, `br_off`=0xFFFF_FFFE → `npc`=0x301C. With `b_flag`=0 → `f_pc`+4.
- Same cycle `req`=1, `eret`=1, `op_npc`=JAL, `stall`=1 → `npc`=0x4180 and the RAS count is unchanged. Next cycle `eret` alone with `epc`=0x3040 → `f_pc` becomes 0x3040.
- `stall` for 2 cycles during JAL → `f_pc` held and no push. `fix`=1 with `fix_pc`=0x3100 → `f_pc`=0x3100 and the RAS is unchanged. Assert reset mid-stream → outputs return to reset values before the next edge.
